// File: rtl/seg_scan_decoder.sv
// Recovers a four-digit frame from a multiplexed 7-segment scan (one-hot digit select plus
// segment pattern), decodes each digit and commits whole frames only.
//
// state | meaning
// HUNT  | waiting for digit 0 (pos 1000) to start a frame
// D1    | digit 0 stored, expecting pos 0100
// D2    | digits 0-1 stored, expecting pos 0010
// D3    | digits 0-2 stored, expecting pos 0001 to commit
module seg_scan_decoder #(
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pos,
  input  logic [7:0] seg,
  output logic [3:0] floor,
  output logic [3:0] status,
  output logic [3:0] pstate,
  output logic [3:0] door,
  output logic [3:0] dig_err,
  output logic       frame_valid,
  output logic       frame_stb,
  output logic       seq_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef logic [TW-1:0] cnt_t;
  localparam cnt_t TO_MAX = cnt_t'(TIMEOUT_CYC);

  typedef enum logic [1:0] {HUNT, D1, D2, D3} state_t;

  state_t     state, state_nxt;
  logic [3:0] pos_m, pos_s, pos_p, last_pos;
  logic [7:0] seg_m, seg_s, seg_p;
  logic [3:0] sh0, sh1, sh2;
  logic       e0, e1, e2;
  cnt_t       to_cnt, cnt_nxt;
  logic       pos_1hot, accept, timeout;
  logic [3:0] dec_val, exp_pos;
  logic       dec_err;
  logic       sh_we0, sh_we1, sh_we2, commit, seq_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_m <= '0;
      pos_s <= '0;
      pos_p <= '0;
      seg_m <= '0;
      seg_s <= '0;
      seg_p <= '0;
    end else begin
      pos_m <= pos;
      pos_s <= pos_m;
      pos_p <= pos_s;
      seg_m <= seg;
      seg_s <= seg_m;
      seg_p <= seg_s;
    end
  end

  // A digit counts once: it must be settled for a cycle and differ from the last one taken.
  assign pos_1hot = (pos_s == 4'b1000) || (pos_s == 4'b0100) ||
                    (pos_s == 4'b0010) || (pos_s == 4'b0001);
  assign accept   = pos_1hot && (pos_s == pos_p) && (seg_s == seg_p) && (pos_s != last_pos);

  always_comb begin
    dec_val = 4'd14;
    dec_err = 1'b0;
    case (seg_s)
      8'h3F:   dec_val = 4'd0;
      8'h06:   dec_val = 4'd1;
      8'h5B:   dec_val = 4'd2;
      8'h4F:   dec_val = 4'd3;
      8'h66:   dec_val = 4'd4;
      8'h6D:   dec_val = 4'd5;
      8'h7D:   dec_val = 4'd6;
      8'h07:   dec_val = 4'd7;
      8'h7F:   dec_val = 4'd8;
      8'h6F:   dec_val = 4'd9;
      8'h01:   dec_val = 4'd10;
      8'h08:   dec_val = 4'd11;
      8'h40:   dec_val = 4'd15;
      default: dec_err = 1'b1;
    endcase
  end

  assign cnt_nxt = accept ? '0 : ((to_cnt == TO_MAX) ? TO_MAX : to_cnt + cnt_t'(1));
  assign timeout = (cnt_nxt == TO_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sh_we0    = 1'b0;
    sh_we1    = 1'b0;
    sh_we2    = 1'b0;
    commit    = 1'b0;
    seq_nxt   = 1'b0;
    case (state)
      HUNT:    exp_pos = 4'b1000;
      D1:      exp_pos = 4'b0100;
      D2:      exp_pos = 4'b0010;
      default: exp_pos = 4'b0001;
    endcase
    if (accept) begin
      if (pos_s == exp_pos) begin
        case (state)
          HUNT: begin sh_we0 = 1'b1; state_nxt = D1; end
          D1:   begin sh_we1 = 1'b1; state_nxt = D2; end
          D2:   begin sh_we2 = 1'b1; state_nxt = D3; end
          D3:   begin commit = 1'b1; state_nxt = HUNT; end
          default: state_nxt = HUNT;
        endcase
      end else if (state != HUNT) begin
        // Out-of-order digit abandons the frame; a fresh digit 0 restarts it at once.
        seq_nxt = 1'b1;
        if (pos_s == 4'b1000) begin
          sh_we0    = 1'b1;
          state_nxt = D1;
        end else begin
          state_nxt = HUNT;
        end
      end
    end else if (timeout) begin
      state_nxt = HUNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pos    <= '0;
      to_cnt      <= '0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      e0          <= 1'b0;
      e1          <= 1'b0;
      e2          <= 1'b0;
      floor       <= '0;
      status      <= '0;
      pstate      <= '0;
      door        <= '0;
      dig_err     <= '0;
      frame_valid <= 1'b0;
      frame_stb   <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      to_cnt    <= cnt_nxt;
      frame_stb <= commit;
      seq_err   <= seq_nxt;
      if (accept) last_pos <= pos_s;
      if (sh_we0) begin sh0 <= dec_val; e0 <= dec_err; end
      if (sh_we1) begin sh1 <= dec_val; e1 <= dec_err; end
      if (sh_we2) begin sh2 <= dec_val; e2 <= dec_err; end
      if (commit) begin
        floor       <= sh0;
        status      <= sh1;
        pstate      <= sh2;
        door        <= dec_val;
        dig_err     <= {e0, e1, e2, dec_err};
        frame_valid <= 1'b1;
      end else if (timeout) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYC, default 2_000_000, meaning the number of clk cycles without an accepted digit before the display is declared stale.
REQ-002 The module SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port pos, input, 4 bits: one-hot digit select from the scanner, 4'b1000 = digit 0 through 4'b0001 = digit 3.
REQ-005 The module SHALL have port seg, input, 8 bits: segment pattern for the selected digit, bit 0 = segment a, active-high.
REQ-006 The module SHALL have ports floor, status, pstate, door, each output, 4 bits: decoded codes for digits 0 to 3.
REQ-007 The module SHALL have port dig_err, output, 4 bits: per-digit unknown-pattern flag for the committed frame, bit 3 = digit 0.
REQ-008 The module SHALL have port frame_valid, output, 1 bit: high while the committed frame is current.
REQ-009 The module SHALL have port frame_stb, output, 1 bit: one-cycle pulse on each frame commit.
REQ-010 The module SHALL have port seq_err, output, 1 bit: one-cycle pulse on an out-of-order digit.

Function
REQ-011 pos and seg SHALL pass through a 2-flop synchronizer (pos_s, seg_s) before any use.
REQ-012 A sample SHALL be accepted only when all of the following hold: pos_s is one-hot; pos_s and seg_s equal their previous-cycle values; pos_s differs from the last accepted pos.
REQ-013 pos_s equal to 4'b0000 or multi-hot SHALL be ignored; it SHALL NOT advance the FSM, flag an error, or clear the last accepted pos.
REQ-014 Decode SHALL map 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 01→10, 08→11 and 40→15 (hex patterns); every other pattern SHALL decode to 14 with the error bit set.
REQ-015 The FSM SHALL have states HUNT, D1, D2 and D3.
- HUNT: an accepted 4'b1000 SHALL store digit 0 in the shadow register and go to D1; other accepted values SHALL be ignored silently.
- D1, D2, D3: the FSM SHALL expect 4'b0100, 4'b0010 and 4'b0001 respectively, store the digit in the shadow register, and advance.
- An accepted 4'b0001 in D3 SHALL commit all four shadow digits and error bits to the outputs and go to HUNT.
REQ-016 In D1, D2 or D3, an accepted pos other than the expected one SHALL pulse seq_err for 1 cycle and discard the shadow frame.
- If that pos is 4'b1000, the FSM SHALL store it as digit 0 and go to D1.
- Otherwise the FSM SHALL go to HUNT.
REQ-017 Commit timing: the outputs, frame_valid=1 and frame_stb=1 SHALL appear on the cycle after the accepting edge.
- End-to-end latency from a pos/seg input change to commit SHALL be 4 clk cycles: 2 synchronizer + 1 stability + 1 register.
REQ-018 Outputs SHALL hold between commits; a partial frame SHALL never alter floor, status, pstate, door or dig_err.
REQ-019 A timeout counter SHALL clear on every accepted sample and increment otherwise, saturating at TIMEOUT_CYC.
REQ-020 When the timeout counter reaches TIMEOUT_CYC, the block SHALL clear frame_valid and force the FSM to HUNT; the digit outputs SHALL hold their values.
REQ-021 Timeout and acceptance on the same cycle: acceptance SHALL win.
REQ-022 The timeout counter SHALL be wide enough for TIMEOUT_CYC; it SHALL NOT wrap.

Reset
REQ-023 Asserting rst SHALL immediately drive: floor, status, pstate, door = 0; dig_err = 0; frame_valid = 0; frame_stb = 0; seq_err = 0.
REQ-024 Asserting rst SHALL also clear the FSM to HUNT, the synchronizers, the shadow registers, the last accepted pos (4'b0000) and the timeout counter.
REQ-025 Reset mid-frame SHALL discard the partial frame; the first commit after release SHALL require a full 1000, 0100, 0010, 0001 sequence.

Verification
REQ-026 Scan digits 3, 10, 0, 8, each held 8 cycles in order 1000, 0100, 0010, 0001 → one frame_stb; floor=3, status=10, pstate=0, door=8, dig_err=0, frame_valid=1, 4 cycles after the 0001 step.
REQ-027 Scan 1000, 0100, then 0001 → seq_err pulses once; no frame_stb; outputs unchanged; the next full sequence commits normally.
REQ-028 seg=8'h55 on digit 2 within an otherwise valid frame → pstate=14 and dig_err=4'b0010 at commit.
REQ-029 seg glitches for 1 cycle mid-digit → the glitch value is not accepted; the committed value is the stable pattern.
REQ-030 With TIMEOUT_CYC=100, stop the scan after a commit → frame_valid falls 100 cycles after the last acceptance; digits hold; restarting the scan recommits.
REQ-031 Assert rst during D2 → all outputs are 0 immediately; after release, a partial 0010/0001 sequence yields no frame_stb.
